// File: rtl/sonic_pcs_pa_pg_pkg.sv
// sonic_pcs_pa_pg_pkg: shared defaults and sizing helpers for the PCS pattern-generator timing adapter.
package sonic_pcs_pa_pg_pkg;
  localparam int DATA_W_DEF = 2;
  localparam int RL_MAX = 4;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sonic_v1_15_pcs_pa_pg_ta_fifo.sv
// sonic_v1_15_pcs_pa_pg_ta_fifo: registered-array FIFO with combinational, zero-masked head read.
module sonic_v1_15_pcs_pa_pg_ta_fifo import sonic_pcs_pa_pg_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, push_en;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push_ready = !reset && !full;
  assign push_en = push_valid && push_ready;
  assign head_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push_en) mem[wr_ptr] <= push_data;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_en);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push_en) - CW'(pop);
    end
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!reset && ((push_en && !pop && full) || (pop && !push_en && empty)))
      $display("ta_fifo: count out of range (count=%0d)", count);
`endif
endmodule

// File: rtl/sonic_v1_15_pcs_pa_pg_after_timing_adapter.sv
// sonic_v1_15_pcs_pa_pg_after_timing_adapter: ready-latency-0 to ready-latency-L Avalon-ST adapter.
// Optional saturating stall counter output enabled by SONIC_PA_PG_TA_STALL_CNT_EN.
module sonic_v1_15_pcs_pa_pg_after_timing_adapter import sonic_pcs_pa_pg_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int READY_LATENCY = 2,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef SONIC_PA_PG_TA_STALL_CNT_EN
  ,
  output logic [15:0]       out_stall_cnt
`endif
);
  localparam int L = (READY_LATENCY > RL_MAX) ? RL_MAX : READY_LATENCY;
  logic [L-1:0] rdy_hist;
  logic rdy_ok, empty;
  assign rdy_ok = rdy_hist[L-1];
  assign out_valid = rdy_ok && !empty;
  sonic_v1_15_pcs_pa_pg_ta_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_data(in_data),
    .push_valid(in_valid),
    .push_ready(in_ready),
    .pop(out_valid),
    .head_data(out_data),
    .empty(empty)
  );
  // out_ready seen L cycles ago decides whether this cycle may emit
  always_ff @(posedge clk)
    rdy_hist <= reset ? '0 : (rdy_hist << 1) | L'(out_ready);
`ifdef SONIC_PA_PG_TA_STALL_CNT_EN
  always_ff @(posedge clk)
    if (reset) out_stall_cnt <= '0;
    else if (!empty && !rdy_ok && out_stall_cnt != 16'hFFFF) out_stall_cnt <= out_stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_sonic_v1_15_pcs_pa_pg_after_timing_adapter.sv
// tb_sonic_v1_15_pcs_pa_pg_after_timing_adapter: scoreboard bench for the timing adapter (L=2, DEPTH=4).
module tb_sonic_v1_15_pcs_pa_pg_after_timing_adapter;
  logic clk = 0, reset = 1;
  logic [1:0] in_data = 0;
  logic in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [1:0] out_data;
`ifdef SONIC_PA_PG_TA_STALL_CNT_EN
  logic [15:0] out_stall_cnt;
`endif
  int tests = 0, fails = 0, stalls = 0;
  logic [1:0] q[$];
  logic [1:0] hist = 0;
  logic acc, rs;
  logic [1:0] d;

  sonic_v1_15_pcs_pa_pg_after_timing_adapter #(.DATA_W(2), .READY_LATENCY(2), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SONIC_PA_PG_TA_STALL_CNT_EN
    ,
    .out_stall_cnt(out_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic send(input logic [1:0] v);
    in_valid = 1;
    in_data = v;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
    end
    chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // expected beats enter the scoreboard on the edge that accepts them
  always begin
    @(negedge clk);
    acc = in_valid && in_ready;
    d = in_data;
    rs = reset;
    @(posedge clk);
    if (rs) q.delete();
    else if (acc) q.push_back(d);
  end

  // monitor: emission only when out_ready was high two cycles back and a beat is queued
  always @(negedge clk) begin
    if (reset) hist = 0;
    else begin
      chk("out_valid", out_valid, hist[1] && q.size() != 0);
      if (q.size() == 0) chk("out_data_mask", out_data, 0);
      else if (out_valid) chk("out_data", out_data, q.pop_front());
      hist = {hist[0], out_ready};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    cyc(3);
    for (int i = 0; i < 8; i++) send(2'(i));
    cyc(4);
    chk("stream_no_stall", stalls, 0);
    fork
      for (int i = 0; i < 10; i++) send(2'(i + 1));
      begin
        cyc(3);
        out_ready = 0;
        cyc(6);
        out_ready = 1;
      end
    join
    cyc(8);
    chk("bp_in_ready_low", stalls != 0, 1);
    chk("bp_drained", q.size(), 0);
    out_ready = 0;
    cyc(4);
    for (int i = 0; i < 4; i++) send(2'(3 - i));
    in_valid = 1;
    in_data = 2'd2;
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("full_pop_valid", out_valid, 1);
    chk("full_pop_in_ready", in_ready, 0);
    @(negedge clk);
    chk("after_pop_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
    cyc(8);
    chk("full_drained", q.size(), 0);
    for (int c = 0; c < 3000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 2'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      cyc(1);
    end
    in_valid = 0;
    out_ready = 1;
    cyc(10);
    chk("rand_drained", q.size(), 0);
    out_ready = 0;
    cyc(3);
    for (int i = 0; i < 3; i++) send(2'(i));
    cyc(3);
    reset = 1;
    out_ready = 1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready_rel", in_ready, 1);
    cyc(6);
`ifdef SONIC_PA_PG_TA_STALL_CNT_EN
    chk("stall_zero", out_stall_cnt, 0);
    fork
      for (int i = 0; i < 5; i++) send(2'(i));
      begin
        out_ready = 0;
        cyc(10);
        out_ready = 1;
      end
    join
    repeat (6) @(negedge clk);
    chk("stall_ten", out_stall_cnt, 16'd10);
    cyc(4);
    out_ready = 0;
    cyc(3);
    for (int i = 0; i < 2; i++) send(2'(i));
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (out_stall_cnt == 16'hFFFE) break;
    end
    chk("stall_fffe", out_stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_sat", out_stall_cnt, 16'hFFFF);
    end
    @(posedge clk);
    #1 out_ready = 1;
    cyc(8);
    chk("stall_drained", q.size(), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
